// File: rtl/bit_manip_pkg.sv
// -----------------------------------------------------------------------------
// bit_manip_pkg
// Shared definitions for the int_bit_manip unit and its sequencer:
//   - W / IDX_W / CNT_W : data width, bit-index width, hit-counter width
//   - OP_*              : request / int_bit_manip operation encodings
//   - state_e           : sequencer FSM states
//   - op_is_scan()      : true for the multi-probe reader operations
// No ports (package).
// -----------------------------------------------------------------------------
package bit_manip_pkg;

    localparam int W     = 64;
    localparam int IDX_W = 6;
    localparam int CNT_W = 7;   // holds 0..64 hits

    localparam logic [2:0] OP_CLR  = 3'd0;
    localparam logic [2:0] OP_SET  = 3'd1;
    localparam logic [2:0] OP_GET  = 3'd2;
    localparam logic [2:0] OP_PASS = 3'd3;
    localparam logic [2:0] OP_FFS  = 3'd4;
    localparam logic [2:0] OP_POPC = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    function automatic logic op_is_scan(input logic [2:0] op);
        return (op == OP_FFS) || (op == OP_POPC);
    endfunction

endpackage

// File: rtl/bit_manip_sequencer_scan_ctr.sv
// -----------------------------------------------------------------------------
// bm_scan_ctr
// Probe index / hit counter for the find-first-set and popcount scans.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : restart the scan (index 0, no hits)
//   i_step         : a non-final probe was captured; advance index, add hit
//   i_hit          : the probe being captured hit (bm_out != 0)
//   i_ffs          : scan is find-first-set (else popcount)
//   o_idx          : index of the probe in flight
//   o_idx_nxt      : index of the following probe
//   o_result       : response value if this capture terminates the scan
//   o_done         : this capture terminates the scan
// -----------------------------------------------------------------------------
module bm_scan_ctr
    import bit_manip_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic             i_hit,
    input  logic             i_ffs,
    output logic [IDX_W-1:0] o_idx,
    output logic [IDX_W-1:0] o_idx_nxt,
    output logic [CNT_W-1:0] o_result,
    output logic             o_done
);

    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_hits;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx  <= '0;
            r_hits <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
            r_hits <= '0;
        end else if (i_step) begin
            r_idx  <= o_idx_nxt;
            r_hits <= r_hits + CNT_W'(i_hit);
        end
    end

    assign o_idx     = r_idx;
    assign o_idx_nxt = r_idx + IDX_W'(1);

    // Last index always terminates; FFS also stops at the first hit.
    assign o_done = (i_ffs && i_hit) || (r_idx == '1);

    // The final probe's hit is folded in here, so the counter itself never
    // has to step past the last index.
    assign o_result = i_ffs ? (i_hit ? {1'b0, r_idx} : CNT_W'(W))
                            : (r_hits + CNT_W'(i_hit));

endmodule

// File: rtl/bit_manip_sequencer.sv
// -----------------------------------------------------------------------------
// bit_manip_sequencer
// Initiator-side controller for int_bit_manip. Accepts one request at a time,
// drives the unit, waits LAT cycles, captures out_bit and returns it. FFS and
// popcount are built by repeated get-bit probes over all 64 positions.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; once valid is raised, the sender holds valid and payload stable
// until that edge.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake
//   req_op, req_opa, req_opb   : operation, operand A, operand B / bit index
//   rsp_valid/rsp_ready        : response handshake
//   rsp_data, rsp_err          : result, rejection flag (data 0 on error)
//   bm_operation/bm_opa/bm_opb : to int_bit_manip
//   bm_out                     : from int_bit_manip
//   busy                       : not in IDLE
// -----------------------------------------------------------------------------
module bit_manip_sequencer
    import bit_manip_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_opa,
    input  logic [W-1:0] req_opb,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic [2:0]   bm_operation,
    output logic [W-1:0] bm_opa,
    output logic [W-1:0] bm_opb,
    input  logic [W-1:0] bm_out,
    output logic         busy
);

    state_e           r_state;
    logic [2:0]       r_op;
    logic [W-1:0]     r_opa;
    logic [W-1:0]     r_opb;
    logic [2:0]       r_wait_cnt;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [W-1:0]     r_rsp_data;
    logic             r_rsp_err;
    logic [2:0]       r_bm_operation;
    logic [W-1:0]     r_bm_opa;
    logic [W-1:0]     r_bm_opb;
    logic             r_busy;

    logic             w_accept;
    logic             w_scan;
    logic             w_bad;
    logic             w_hit;
    logic             w_step;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_result;
    logic             w_done;

    assign w_accept = (r_state == ST_IDLE) && req_valid && r_req_ready;
    assign w_scan   = op_is_scan(r_op);
    // Reserved ops, or an out-of-range index for the single-bit ops.
    assign w_bad    = (r_op > OP_POPC) || ((r_op <= OP_GET) && (|r_opb[W-1:IDX_W]));
    assign w_hit    = |bm_out;
    assign w_step   = (r_state == ST_CAPTURE) && w_scan && !w_done;

    bm_scan_ctr u_scan_ctr (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clear   (w_accept),
        .i_step    (w_step),
        .i_hit     (w_hit),
        .i_ffs     (r_op == OP_FFS),
        .o_idx     (w_idx),
        .o_idx_nxt (w_idx_nxt),
        .o_result  (w_result),
        .o_done    (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_PASS;
            r_opa          <= '0;
            r_opb          <= '0;
            r_wait_cnt     <= '0;
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_bm_operation <= OP_PASS;
            r_bm_opa       <= '0;
            r_bm_opb       <= '0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_opa       <= req_opa;
                        r_opb       <= req_opb;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_bad) begin
                        // Rejected: the unit is never touched, bm_* keep their values.
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_bm_operation <= w_scan ? OP_GET : r_op;
                        r_bm_opa       <= r_opa;
                        r_bm_opb       <= w_scan ? {{(W-IDX_W){1'b0}}, w_idx} : r_opb;
                        r_wait_cnt     <= '0;
                        r_state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 3'(LAT - 1)) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (!w_scan || w_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= w_scan ? {{(W-CNT_W){1'b0}}, w_result} : bm_out;
                        r_state     <= ST_RESP;
                    end else begin
                        // Capture edge doubles as the issue of the next probe, so
                        // every probe after the first costs LAT+1 cycles.
                        r_bm_opb   <= {{(W-IDX_W){1'b0}}, w_idx_nxt};
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign bm_operation = r_bm_operation;
    assign bm_opa       = r_bm_opa;
    assign bm_opb       = r_bm_opb;
    assign busy         = r_busy;

endmodule

// File: tb/tb_bit_manip_sequencer.sv
module tb_bit_manip_sequencer;
  import bit_manip_pkg::*;

  localparam int LAT = 1;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_opa;
  logic [W-1:0] req_opb;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [2:0]   bm_operation;
  logic [W-1:0] bm_opa;
  logic [W-1:0] bm_opb;
  logic [W-1:0] bm_out;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  bit_manip_sequencer #(.LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_opa      (req_opa),
    .req_opb      (req_opb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .bm_operation (bm_operation),
    .bm_opa       (bm_opa),
    .bm_opb       (bm_opb),
    .bm_out       (bm_out),
    .busy         (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // int_bit_manip stand-in with one cycle of latency
  function automatic logic [W-1:0] ibm(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a & ~(64'd1 << b[5:0]);
      3'd1:    return a | (64'd1 << b[5:0]);
      3'd2:    return a & (64'd1 << b[5:0]);
      3'd3:    return a;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) bm_out <= ibm(bm_operation, bm_opa, bm_opb);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: result, error, edges from accept to rsp_valid,
  // and the last values left on the bm_* bus.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic e, output int lat,
                       output logic [2:0] mop, output logic [W-1:0] mopb);
    int probes;
    logic found;
    probes = 0;
    found  = 1'b0;
    d      = '0;
    e      = 1'b0;
    mop    = op;
    mopb   = b;
    if (op >= 3'd6 || (op <= 3'd2 && b >= 64)) begin
      e = 1'b1;
    end else if (op <= 3'd3) begin
      probes = 1;
      if (op == 3'd0) d = a & ~(64'd1 << b);
      else if (op == 3'd1) d = a | (64'd1 << b);
      else if (op == 3'd2) d = a & (64'd1 << b);
      else d = a;
    end else if (op == 3'd4) begin
      mop = 3'd2;
      for (int i = 0; i < 64; i++) begin
        if (!found) begin
          probes++;
          if (a[i]) begin
            found = 1'b1;
            d = 64'(i);
          end
        end
      end
      if (!found) d = 64;
      mopb = 64'(probes - 1);
    end else begin
      mop = 3'd2;
      probes = 64;
      for (int i = 0; i < 64; i++) d = d + 64'(a[i]);
      mopb = 63;
    end
    lat = 1 + probes * (LAT + 1);
  endtask

  // Per-cycle compare process: handshake invariants and backpressure stability
  logic         p_valid = 1'b0;
  logic         p_ready = 1'b1;
  logic         p_err   = 1'b0;
  logic [W-1:0] p_data  = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_vs_busy", req_ready, !busy);
      if (p_valid && !p_ready) begin
        chk("stall_valid", rsp_valid, 1'b1);
        chk("stall_data", rsp_data, p_data);
        chk("stall_err", rsp_err, p_err);
      end
      if (rsp_valid && rsp_err) chk("err_data_zero", rsp_data, '0);
    end
    p_valid = rsp_valid;
    p_ready = rsp_ready;
    p_err   = rsp_err;
    p_data  = rsp_data;
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_bm_operation"}, bm_operation, 3'd3);
    chk({tag, "_bm_opa"}, bm_opa, '0);
    chk({tag, "_bm_opb"}, bm_opb, '0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // driver: one request, checked against the model and a hand-computed literal
  task automatic run_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lit_d, input logic lit_e, input int lit_lat,
                         input int hold);
    logic [W-1:0] md, mopb, s_opa, s_opb, e_d;
    logic         me;
    logic [2:0]   mop, s_op;
    int           mlat, n, g;
    model(op, a, b, md, me, mlat, mop, mopb);
    exp_q.push_back(md);
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready_idle", req_ready, 1'b1);
    s_op  = bm_operation;
    s_opa = bm_opa;
    s_opb = bm_opb;
    req_valid = 1'b1;
    req_op    = op;
    req_opa   = a;
    req_opb   = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_opa   = {$urandom, $urandom};
    req_opb   = {$urandom, $urandom};
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    e_d = exp_q.pop_front();
    chk("latency_model", 64'(n), 64'(mlat));
    chk("latency_lit", 64'(n), 64'(lit_lat));
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("data_model", rsp_data, e_d);
    chk("data_lit", rsp_data, lit_d);
    chk("err_model", rsp_err, me);
    chk("err_lit", rsp_err, lit_e);
    if (me) begin
      chk("bus_op_kept", bm_operation, s_op);
      chk("bus_opa_kept", bm_opa, s_opa);
      chk("bus_opb_kept", bm_opb, s_opb);
    end else begin
      chk("bus_op", bm_operation, mop);
      chk("bus_opa", bm_opa, a);
      chk("bus_opb", bm_opb, mopb);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_data, lit_d);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("consumed", rsp_valid, 1'b0);
    chk("req_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    int g;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_opa   = '0;
    req_opb   = '0;
    rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst0");
    repeat (3) @(negedge clk);
    chk_reset_vals("rst1");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_edge_ready", req_ready, 1'b1);
    chk("first_edge_busy", busy, 1'b0);
    mon_en = 1'b1;

    // single-bit ops and pass
    run_req(3'd0, 64'd65535, 64'd15, 64'd32767, 1'b0, 3, 0);
    run_req(3'd1, 64'd0, 64'd15, 64'd32768, 1'b0, 3, 0);
    run_req(3'd2, 64'd4, 64'd3, 64'd0, 1'b0, 3, 0);
    run_req(3'd2, 64'd65535, 64'd8, 64'd256, 1'b0, 3, 0);
    run_req(3'd3, 64'd65535, 64'hFFFF_FFFF_FFFF_FFFF, 64'd65535, 1'b0, 3, 0);
    run_req(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3, 0);
    // find-first-set
    run_req(3'd4, 64'h80, 64'd0, 64'd7, 1'b0, 17, 0);
    run_req(3'd4, 64'h0, 64'd0, 64'd64, 1'b0, 129, 0);
    run_req(3'd4, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 1'b0, 129, 0);
    run_req(3'd4, 64'hF000, 64'd99, 64'd12, 1'b0, 27, 0);
    // popcount
    run_req(3'd5, 64'd65535, 64'd0, 64'd16, 1'b0, 129, 0);
    run_req(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd64, 1'b0, 129, 0);
    run_req(3'd5, 64'h0, 64'd0, 64'd0, 1'b0, 129, 0);
    // errors
    run_req(3'd2, 64'd65535, 64'd64, 64'd0, 1'b1, 1, 0);
    run_req(3'd6, 64'd1, 64'd1, 64'd0, 1'b1, 1, 0);
    run_req(3'd7, 64'd1, 64'd0, 64'd0, 1'b1, 1, 0);
    // backpressure
    run_req(3'd1, 64'h10, 64'd40, 64'h100_0000_0010, 1'b0, 3, 5);

    // reset in the middle of the 20th popcount probe
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_opa   = 64'hFFFF_FFFF_FFFF_FFFF;
    req_opb   = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    chk("busy_before_rst", busy, 1'b1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1 chk_reset_vals("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("no_stale_rsp", rsp_valid, 1'b0);
    end
    mon_en = 1'b1;
    run_req(3'd3, 64'd5, 64'd0, 64'd5, 1'b0, 3, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
